// File: rtl/irq_ctl.sv
// Interrupt/reset sequencer: synchronises NIRQ IRQ lines plus NMI, arbitrates by priority
// and holds one registered request (kind, channel, vector low byte) until the vector fetch is acked.
module irq_ctl #(
    parameter int          NIRQ        = 4,
    parameter logic [7:0]  EDGE_MASK   = 8'h00,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  VEC_BASE    = 8'hE0
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [NIRQ-1:0] IRQ,
    input  logic            NMI,
    input  logic            I,
    input  logic            sync,
    input  logic            ack,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_di,
    output logic            take,
    output logic [7:0]      vec,
    output logic [1:0]      kind,
    output logic [2:0]      chan,
    output logic [NIRQ-1:0] pending
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_TAKEN    = 2'd1;
    localparam logic [1:0] S_RST_PEND = 2'd2;

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_IRQ  = 2'b01;
    localparam logic [1:0] K_NMI  = 2'b10;
    localparam logic [1:0] K_RST  = 2'b11;

    logic [1:0]      r_state;
    logic            r_take;
    logic [7:0]      r_vec;
    logic [1:0]      r_kind;
    logic [2:0]      r_chan;
    logic [NIRQ-1:0] r_mask;
    logic            r_nmi_prev;
    logic            r_nmi_pend;

    logic [NIRQ-1:0] w_irq_s;
    logic            w_nmi_s;
    logic [NIRQ-1:0] w_pend;
    logic [NIRQ-1:0] w_q;
    logic [2:0]      w_sel;
    logic [7:0]      w_irq_vec;
    logic            w_irq_ack;
    logic            w_nmi_ack;
    logic            w_nmi_rise;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_irq_s = IRQ;
            assign w_nmi_s = NMI;
        end else begin : g_sync
            logic [NIRQ-1:0]        r_irq_sync [SYNC_STAGES];
            logic [SYNC_STAGES-1:0] r_nmi_sync;

            always_ff @(posedge clk) begin
                if (RST) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_irq_sync[s] <= '0;
                    end
                    r_nmi_sync <= '0;
                end else begin
                    r_irq_sync[0] <= IRQ;
                    r_nmi_sync[0] <= NMI;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_irq_sync[s] <= r_irq_sync[s-1];
                        r_nmi_sync[s] <= r_nmi_sync[s-1];
                    end
                end
            end

            assign w_irq_s = r_irq_sync[SYNC_STAGES-1];
            assign w_nmi_s = r_nmi_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_irq_ack  = ack && (r_state == S_TAKEN) && (r_kind == K_IRQ);
    assign w_nmi_ack  = ack && (r_state == S_TAKEN) && (r_kind == K_NMI);
    assign w_nmi_rise = w_nmi_s & ~r_nmi_prev;

    // Edge channels keep a latch (a fresh edge beats a same-cycle ack); level channels follow the input.
    genvar gi;
    generate
        for (gi = 0; gi < NIRQ; gi++) begin : g_chan
            if (EDGE_MASK[gi]) begin : g_edge
                logic r_prev;
                logic r_latch;
                logic w_rise;
                logic w_clr;

                assign w_rise = w_irq_s[gi] & ~r_prev;
                assign w_clr  = w_irq_ack && (r_chan == 3'(gi));

                always_ff @(posedge clk) begin
                    if (RST) begin
                        r_prev  <= 1'b0;
                        r_latch <= 1'b0;
                    end else begin
                        r_prev  <= w_irq_s[gi];
                        r_latch <= w_rise | (r_latch & ~w_clr);
                    end
                end

                assign w_pend[gi] = r_latch;
            end else begin : g_level
                assign w_pend[gi] = w_irq_s[gi];
            end
        end
    endgenerate

    assign w_q     = w_pend & r_mask & {NIRQ{~I}};
    assign pending = w_pend & r_mask;

    always_comb begin
        w_sel = 3'd0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (w_q[k]) begin
                w_sel = 3'(k);
            end
        end
    end

    // Channel 0 shares the BRK vector; the rest are packed in pairs above VEC_BASE.
    assign w_irq_vec = (w_sel == 3'd0) ? 8'hFE
                                       : VEC_BASE + {4'b0000, w_sel, 1'b0} - 8'd2;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= S_RST_PEND;
            r_take     <= 1'b1;
            r_vec      <= 8'hFC;
            r_kind     <= K_RST;
            r_chan     <= 3'd0;
            r_mask     <= '1;
            r_nmi_prev <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_prev <= w_nmi_s;
            r_nmi_pend <= w_nmi_rise | (r_nmi_pend & ~w_nmi_ack);
            if (mask_we) begin
                r_mask <= mask_di;
            end

            case (r_state)
                S_IDLE: begin
                    if (sync && r_nmi_pend) begin
                        r_state <= S_TAKEN;
                        r_take  <= 1'b1;
                        r_vec   <= 8'hFA;
                        r_kind  <= K_NMI;
                        r_chan  <= 3'd0;
                    end else if (sync && (|w_q)) begin
                        r_state <= S_TAKEN;
                        r_take  <= 1'b1;
                        r_vec   <= w_irq_vec;
                        r_kind  <= K_IRQ;
                        r_chan  <= w_sel;
                    end
                end
                S_TAKEN, S_RST_PEND: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                        r_take  <= 1'b0;
                        r_vec   <= 8'hFF;
                        r_kind  <= K_NONE;
                        r_chan  <= 3'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_take  <= 1'b0;
                    r_vec   <= 8'hFF;
                    r_kind  <= K_NONE;
                    r_chan  <= 3'd0;
                end
            endcase
        end
    end

    assign take = r_take;
    assign vec  = r_vec;
    assign kind = r_kind;
    assign chan = r_chan;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: a level-heavy instance (ch1 edge) and an edge instance (ch0/ch1 edge).
module tb_irq_ctl;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] IRQ = '0;
    logic       NMI = 1'b0;
    logic       I = 1'b0;
    logic       sync = 1'b0;
    logic       ack = 1'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_di = '0;

    logic       l_take, e_take;
    logic [7:0] l_vec, e_vec;
    logic [1:0] l_kind, e_kind;
    logic [2:0] l_chan, e_chan;
    logic [3:0] l_pend, e_pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctl #(.NIRQ(4), .EDGE_MASK(8'h02), .SYNC_STAGES(2), .VEC_BASE(8'hE0)) u_lvl (
        .clk(clk), .RST(RST), .IRQ(IRQ), .NMI(NMI), .I(I), .sync(sync), .ack(ack),
        .mask_we(mask_we), .mask_di(mask_di),
        .take(l_take), .vec(l_vec), .kind(l_kind), .chan(l_chan), .pending(l_pend)
    );

    irq_ctl #(.NIRQ(4), .EDGE_MASK(8'h03), .SYNC_STAGES(2), .VEC_BASE(8'hE0)) u_edg (
        .clk(clk), .RST(RST), .IRQ(IRQ), .NMI(NMI), .I(I), .sync(sync), .ack(ack),
        .mask_we(mask_we), .mask_di(mask_di),
        .take(e_take), .vec(e_vec), .kind(e_kind), .chan(e_chan), .pending(e_pend)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; IRQ = '0; NMI = 1'b0; I = 1'b0; sync = 1'b0; ack = 1'b0; mask_we = 1'b0;
        step(2);
        RST = 1'b0; ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            checks++;
            if ({l_take, l_vec, l_kind, l_chan} !== {1'b1, 8'hFC, 2'b11, 3'd0}) begin
                errors++;
                $display("FAIL rst_hold: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b1, 8'hFC, 2'b11, 3'd0});
            end
        end
        RST = 1'b0;
        step(2);
        checks++;
        if ({l_take, l_vec, l_kind, l_chan} !== {1'b1, 8'hFC, 2'b11, 3'd0}) begin
            errors++;
            $display("FAIL rst_pend_after_release: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b1, 8'hFC, 2'b11, 3'd0});
        end
        checks++;
        if (l_pend !== 4'b0000) begin
            errors++;
            $display("FAIL rst_pending: got %b want 0000", l_pend);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind, l_chan} !== {1'b0, 8'hFF, 2'b00, 3'd0}) begin
            errors++;
            $display("FAIL rst_ack_idle: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b0, 8'hFF, 2'b00, 3'd0});
        end
        $display("reset: hold 3 cycles, release, ack -> idle");
    endtask

    task automatic test_edge_level();
        do_reset();
        IRQ = 4'b1010;
        step(3);
        checks++;
        if (l_pend !== 4'b1010) begin
            errors++;
            $display("FAIL el_pending: got %b want 1010", l_pend);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if ({l_take, l_pend} !== {1'b0, 4'b1010}) begin
            errors++;
            $display("FAIL el_idle_ack_ignored: got %h want %h", {l_take, l_pend}, {1'b0, 4'b1010});
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind, l_chan} !== {1'b1, 8'hE0, 2'b01, 3'd1}) begin
            errors++;
            $display("FAIL el_take_ch1: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b1, 8'hE0, 2'b01, 3'd1});
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if ({l_take, l_pend} !== {1'b0, 4'b1000}) begin
            errors++;
            $display("FAIL el_ch1_latch_clear: got %h want %h", {l_take, l_pend}, {1'b0, 4'b1000});
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind, l_chan} !== {1'b1, 8'hE4, 2'b01, 3'd3}) begin
            errors++;
            $display("FAIL el_take_ch3: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b1, 8'hE4, 2'b01, 3'd3});
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        IRQ = '0;
        $display("edge_level: ch1 edge then ch3 level taken in order");
    endtask

    task automatic test_nmi();
        do_reset();
        I = 1'b1; IRQ = 4'b0001; NMI = 1'b1;
        step(3);
        checks++;
        if ({l_take, l_pend} !== {1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL nmi_no_sync: got %h want %h", {l_take, l_pend}, {1'b0, 4'b0001});
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind, l_chan} !== {1'b1, 8'hFA, 2'b10, 3'd0}) begin
            errors++;
            $display("FAIL nmi_take: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b1, 8'hFA, 2'b10, 3'd0});
        end
        NMI = 1'b0;
        step(3);
        NMI = 1'b1;
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (l_take !== 1'b0) begin
            errors++;
            $display("FAIL nmi_ack: got take=%b want 0", l_take);
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind, l_chan} !== {1'b1, 8'hFA, 2'b10, 3'd0}) begin
            errors++;
            $display("FAIL nmi_edge_on_ack_retaken: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b1, 8'hFA, 2'b10, 3'd0});
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if (l_take !== 1'b0) begin
            errors++;
            $display("FAIL nmi_consumed_irq_masked_by_i: got take=%b want 0", l_take);
        end
        I = 1'b0; IRQ = '0; NMI = 1'b0;
        $display("nmi: taken with I=1, edge on ack cycle retaken, then consumed");
    endtask

    task automatic test_freeze();
        do_reset();
        IRQ = 4'b0100;
        step(2);
        checks++;
        if (l_pend !== 4'b0100) begin
            errors++;
            $display("FAIL frz_level_latency: got %b want 0100", l_pend);
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind, l_chan} !== {1'b1, 8'hE2, 2'b01, 3'd2}) begin
            errors++;
            $display("FAIL frz_take_ch2: got %h want %h", {l_take, l_vec, l_kind, l_chan}, {1'b1, 8'hE2, 2'b01, 3'd2});
        end
        IRQ = 4'b0001;
        sync = 1'b1;
        step(3);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind, l_chan, l_pend} !== {1'b1, 8'hE2, 2'b01, 3'd2, 4'b0001}) begin
            errors++;
            $display("FAIL frz_held: got %h want %h", {l_take, l_vec, l_kind, l_chan, l_pend}, {1'b1, 8'hE2, 2'b01, 3'd2, 4'b0001});
        end
        IRQ = '0;
        step(3);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if (l_take !== 1'b0) begin
            errors++;
            $display("FAIL frz_ch0_never_taken: got take=%b want 0", l_take);
        end
        $display("freeze: ch2 request held while ch0 pulsed");
    endtask

    task automatic test_mask();
        do_reset();
        mask_we = 1'b1; mask_di = 4'b1110;
        step(1);
        mask_we = 1'b0;
        IRQ = 4'b0001;
        step(1);
        IRQ = '0;
        step(4);
        checks++;
        if (e_pend !== 4'b0000) begin
            errors++;
            $display("FAIL mask_pending_hidden: got %b want 0000", e_pend);
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if (e_take !== 1'b0) begin
            errors++;
            $display("FAIL mask_no_take: got take=%b want 0", e_take);
        end
        mask_we = 1'b1; mask_di = 4'b1111;
        step(1);
        mask_we = 1'b0;
        checks++;
        if (e_pend !== 4'b0001) begin
            errors++;
            $display("FAIL mask_unmask_pending: got %b want 0001", e_pend);
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({e_take, e_vec, e_kind, e_chan} !== {1'b1, 8'hFE, 2'b01, 3'd0}) begin
            errors++;
            $display("FAIL mask_take_ch0: got %h want %h", {e_take, e_vec, e_kind, e_chan}, {1'b1, 8'hFE, 2'b01, 3'd0});
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if ({e_take, e_pend} !== {1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL mask_ack_clear: got %h want %h", {e_take, e_pend}, {1'b0, 4'b0000});
        end
        $display("mask: edge latch kept while masked, taken after unmask");
    endtask

    task automatic test_reset_in_taken();
        do_reset();
        IRQ = 4'b0010; NMI = 1'b1;
        step(3);
        checks++;
        if (l_pend !== 4'b0010) begin
            errors++;
            $display("FAIL rit_latch_set: got %b want 0010", l_pend);
        end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_kind} !== {1'b1, 2'b10}) begin
            errors++;
            $display("FAIL rit_nmi_take: got %h want %h", {l_take, l_kind}, {1'b1, 2'b10});
        end
        IRQ = '0; NMI = 1'b0; RST = 1'b1;
        step(1);
        checks++;
        if ({l_take, l_vec, l_kind, l_chan, l_pend} !== {1'b1, 8'hFC, 2'b11, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL rit_reset: got %h want %h", {l_take, l_vec, l_kind, l_chan, l_pend}, {1'b1, 8'hFC, 2'b11, 3'd0, 4'b0000});
        end
        RST = 1'b0;
        step(1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_kind} !== {1'b0, 8'hFF, 2'b00}) begin
            errors++;
            $display("FAIL rit_latches_cleared: got %h want %h", {l_take, l_vec, l_kind}, {1'b0, 8'hFF, 2'b00});
        end
        $display("reset_in_taken: NMI request replaced by reset, latches cleared");
    endtask

    task automatic test_back_to_back();
        do_reset();
        IRQ = 4'b1000;
        step(2);
        sync = 1'b1;
        step(1);
        checks++;
        if ({l_take, l_chan} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", {l_take, l_chan}, {1'b1, 3'd3});
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (l_take !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got take=%b want 0", l_take);
        end
        step(1);
        sync = 1'b0;
        checks++;
        if ({l_take, l_vec, l_chan} !== {1'b1, 8'hE4, 3'd3}) begin
            errors++;
            $display("FAIL b2b_second: got %h want %h", {l_take, l_vec, l_chan}, {1'b1, 8'hE4, 3'd3});
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        IRQ = '0;
        $display("back_to_back: take, one-cycle gap, take again");
    endtask

    initial begin
        test_reset();
        test_edge_level();
        test_nmi();
        test_freeze();
        test_mask();
        test_reset_in_taken();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
- Parametrised interrupt and reset sequencer feeding the CPU core's microcode control.
- Replaces the single IRQ/NMI/RST input trio with NIRQ maskable IRQ channels (per-channel edge or level mode), an edge-latched NMI and a reset request.
- Arbitrates by priority and presents one registered request, with its vector low byte, on an instruction boundary (sync). The request is held until the sequencer acknowledges the vector fetch.

Parameters:
- NIRQ, 4, number of IRQ channels (1..8)
- EDGE_MASK, 0, bit k=1: channel k edge-triggered (rising); bit k=0: level-triggered
- SYNC_STAGES, 2, input synchroniser flops on IRQ/NMI (0..2)
- VEC_BASE, 8'hE0, vector low byte for channel 1; channel k>=1 uses VEC_BASE+2*(k-1). Must satisfy VEC_BASE+2*(NIRQ-2) < 8'hFA.

Ports:
- clk  in  1  CPU clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- IRQ  in  NIRQ  interrupt requests, active-high
- NMI  in  1  non-maskable request, active-high, rising-edge sensitive
- I  in  1  CPU interrupt-disable flag; masks IRQ channels only
- sync  in  1  instruction boundary from control
- ack  in  1  one-cycle pulse: vector fetched, request consumed
- mask_we  in  1  write enable for the channel enable mask
- mask_di  in  NIRQ  new mask (1 = channel enabled)
- take  out  1  registered: interrupt/reset sequence requested
- vec  out  8  vector low byte (high byte is 8'hFF, supplied via abh_ff)
- kind  out  2  00 none, 01 IRQ, 10 NMI, 11 RST
- chan  out  3  IRQ channel number when kind=01, else 0
- pending  out  NIRQ  per-channel qualified-pending status: pend & mask

Behaviour:
- Reset (RST=1, any state, including mid-request):
  - state RST_PEND; take=1, vec=8'hFC, kind=11, chan=0.
  - All edge latches and the NMI latch cleared; mask = all ones; synchroniser flops cleared.
  - Outputs hold while RST stays high.
- RST_PEND: take stays 1 without needing sync. The first ack after RST deasserts goes to IDLE (take=0, kind=00, vec=8'hFF) on the next edge.
- Inputs pass through SYNC_STAGES flops (0 = direct). The edge detector compares the synchronised value with its previous value.
- Per-channel pend[k]:
  - Level mode: equals synchronised IRQ[k].
  - Edge mode: set on a rising edge, cleared by an ack for that channel. A set and a clear on the same cycle leaves it set.
- nmi_pend: set on an NMI rising edge, cleared by an NMI ack. A new edge on the ack cycle wins, so it stays set.
- Qualified IRQ: q[k] = pend[k] & mask[k] & ~I. NMI ignores I and mask.
- Priority: NMI > channel 0 > channel 1 > ... > channel NIRQ-1.
- IDLE -> TAKEN: on an edge with sync=1 and any request qualified. Registered in the same edge:
  - take=1, kind, chan.
  - vec: NMI 8'hFA; channel 0 8'hFE (shared with BRK); channel k>=1 VEC_BASE+2*(k-1).
  - Without sync=1 there is no transition.
- TAKEN: take, vec, kind and chan are frozen until ack, even if the source deasserts or a higher-priority request arrives. On ack: clear the consumed edge/NMI latch, go to IDLE, take=0 next edge.
- Back-to-back: take can reassert on the first sync after returning to IDLE, giving a minimum one-cycle gap at take=0.
- ack in IDLE is ignored.
- Latency: input change -> pending visible after SYNC_STAGES+1 edges (edge mode) or SYNC_STAGES edges (level). A qualified request with sync high -> take=1 one edge later.
- Mask: mask_we loads mask_di on the edge. Masking an edge-latched channel does not clear its latch; it re-qualifies when unmasked.
- chan is 3 bits fixed; upper bits are 0 when NIRQ<8.

Test Plan:
- RST pulse 3 cycles, then idle -> take=1, vec=FC, kind=11 throughout and after release; ack -> take=0, vec=FF next edge.
- NIRQ=4, EDGE_MASK=4'b0010, I=0: raise IRQ[1] and IRQ[3], pulse sync -> vec=E0, chan=1. ack -> IRQ[1] latch clears. Next sync -> vec=E4, chan=3 (level IRQ[3] still high).
- NMI rising edge with I=1 and IRQ[0] high -> take, kind=10, vec=FA. Second NMI edge on the ack cycle -> nmi_pend remains, re-taken on the next sync.
- IRQ[0] level pulse during TAKEN(chan 2), deasserted before ack -> request frozen at chan 2; IRQ[0] never taken.
- mask_di=4'b1110, edge pulse on channel 0 -> pending[0]=0, no take. Unmask -> pending[0]=1, take with vec=FE on the next sync.
- RST asserted while TAKEN(NMI) -> next edge kind=11, vec=FC, nmi_pend and latches cleared.
